screen_sequencer: RTL and testbench

//  Top-level screen FSM for Snake. Sequences the full-screen fill drawer through

---
 rtl/snake_pkg.sv | 33 +++
 rtl/fill_counter.sv | 32 +++
 rtl/screen_sequencer.sv | 149 ++++++++++++++
 tb/tb_screen_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants and screen-state encoding for the Snake display path.
package snake_pkg;

    localparam int SCREEN_W       = 160;
    localparam int SCREEN_H       = 120;
    localparam int PIXELS_DEFAULT = SCREEN_W * SCREEN_H;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;

    localparam logic [2:0] S_T_FILL = 3'd0;
    localparam logic [2:0] S_T_WAIT = 3'd1;
    localparam logic [2:0] S_C_FILL = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_G_FILL = 3'd4;
    localparam logic [2:0] S_F_WAIT = 3'd5;
    localparam logic [2:0] S_F_FILL = 3'd6;

    typedef enum logic [2:0] {
        T_FILL = S_T_FILL,
        T_WAIT = S_T_WAIT,
        C_FILL = S_C_FILL,
        PLAY   = S_PLAY,
        G_FILL = S_G_FILL,
        F_WAIT = S_F_WAIT,
        F_FILL = S_F_FILL
    } screen_state_t;

    function automatic logic is_fill(input screen_state_t s);
        return (s == T_FILL) || (s == C_FILL) || (s == G_FILL) || (s == F_FILL);
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Pixel counter shared by every full-screen fill: entry pulse, plot window and end-of-fill.
module fill_counter
    import snake_pkg::*;
#(
    parameter int PIXELS = PIXELS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic start,
    output logic done,
    output logic plot
);

    localparam logic [14:0] LAST = 15'(PIXELS);

    logic [14:0] pix_cnt;

    // Count 0..PIXELS; the extra cycle covers the drawer's RAM latency.
    always_ff @(posedge clk) begin
        if (rst || !run || done) begin
            pix_cnt <= '0;
        end else begin
            pix_cnt <= pix_cnt + 15'd1;
        end
    end

    assign start = run && (pix_cnt == '0);
    assign done  = run && (pix_cnt == LAST);
    assign plot  = run && (pix_cnt != '0);

endmodule

// File: rtl/screen_sequencer.sv
// Snake screen FSM: sequences title/clear/game-over/flash fills and muxes the VGA plot port.
module screen_sequencer
    import snake_pkg::*;
#(
    parameter int PIXELS       = PIXELS_DEFAULT,
    parameter int FLASH_FRAMES = 15,
    parameter int FLASH_COUNT  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_key,
    input  logic       game_over,
    input  logic       frame_tick,
    input  logic       game_req,
    input  logic [7:0] game_x,
    input  logic [6:0] game_y,
    input  logic [2:0] game_colour,
    input  logic [7:0] fill_x,
    input  logic [6:0] fill_y,
    input  logic [2:0] fill_colour,
    output logic       fill_rst,
    output logic       show_title,
    output logic       show_black,
    output logic       show_gameover,
    output logic       flash,
    output logic       game_grant,
    output logic       busy,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour
);

    localparam logic [3:0] FRAME_LAST = 4'(FLASH_FRAMES - 1);
    localparam logic [2:0] FLASH_LAST = 3'(FLASH_COUNT - 1);

    screen_state_t state, state_next;
    logic          held;
    logic [2:0]    flash_cnt, flash_next;
    logic [3:0]    frame_cnt, frame_next;

    logic in_fill, fill_start, fill_done, fill_plot;

    // held keeps every output quiet while rst is applied; T_FILL entry follows its release.
    assign in_fill = !held && is_fill(state);

    fill_counter #(.PIXELS(PIXELS)) u_fill_counter (
        .clk   (clk),
        .rst   (rst),
        .run   (in_fill),
        .start (fill_start),
        .done  (fill_done),
        .plot  (fill_plot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= T_FILL;
            held      <= 1'b1;
            flash_cnt <= '0;
            frame_cnt <= '0;
        end else if (held) begin
            held <= 1'b0;
        end else begin
            state     <= state_next;
            flash_cnt <= flash_next;
            frame_cnt <= frame_next;
        end
    end

    always_comb begin
        state_next    = state;
        flash_next    = flash_cnt;
        frame_next    = frame_cnt;
        fill_rst      = 1'b0;
        show_title    = 1'b0;
        show_black    = 1'b0;
        show_gameover = 1'b0;
        flash         = 1'b0;
        game_grant    = 1'b0;
        busy          = 1'b0;
        plot          = 1'b0;
        x             = '0;
        y             = '0;
        colour        = BLACK;

        case (state)
            T_FILL: if (fill_done) state_next = T_WAIT;
            T_WAIT: if (start_key) state_next = C_FILL;
            C_FILL: if (fill_done) state_next = PLAY;
            PLAY:   if (game_over) state_next = G_FILL;
            G_FILL: begin
                if (fill_done) begin
                    state_next = F_WAIT;
                    frame_next = '0;
                    flash_next = '0;
                end
            end
            F_WAIT: begin
                if (frame_tick) begin
                    if (frame_cnt == FRAME_LAST) begin
                        state_next = F_FILL;
                        frame_next = '0;
                    end else begin
                        frame_next = frame_cnt + 4'd1;
                    end
                end
            end
            F_FILL: begin
                if (fill_done) begin
                    flash_next = flash_cnt + 3'd1;
                    state_next = (flash_cnt == FLASH_LAST) ? T_WAIT : F_WAIT;
                end
            end
            default: state_next = T_FILL;
        endcase

        if (!held) begin
            case (state)
                T_FILL: show_title    = 1'b1;
                C_FILL: show_black    = 1'b1;
                G_FILL: show_gameover = 1'b1;
                F_FILL: begin
                    flash      = !flash_cnt[0];
                    show_title = flash_cnt[0];
                end
                PLAY: begin
                    // A collision in the same cycle suppresses the game's write.
                    game_grant = 1'b1;
                    plot       = game_req && !game_over;
                    x          = game_x;
                    y          = game_y;
                    colour     = game_colour;
                end
                default: ;
            endcase
        end

        if (in_fill) begin
            busy     = 1'b1;
            fill_rst = fill_start;
            plot     = fill_plot;
            x        = fill_x;
            y        = fill_y;
            colour   = fill_colour;
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: directed screen flow, PLAY mux table, randomized run vs reference model.
module tb_screen_sequencer;
    import snake_pkg::*;

    // Fill length scaled down so the complete flash sequence fits a short run.
    localparam int PIX = 1000;
    localparam int FF  = 15;
    localparam int FC  = 6;

    bit clk;
    always #5 clk = ~clk;

    logic       rst, start_key, game_over, frame_tick, game_req;
    logic [7:0] game_x, fill_x;
    logic [6:0] game_y, fill_y;
    logic [2:0] game_colour, fill_colour;
    logic       fill_rst, show_title, show_black, show_gameover, flash;
    logic       game_grant, busy, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    screen_sequencer #(.PIXELS(PIX), .FLASH_FRAMES(FF), .FLASH_COUNT(FC)) dut (
        .clk(clk), .rst(rst), .start_key(start_key), .game_over(game_over),
        .frame_tick(frame_tick), .game_req(game_req), .game_x(game_x),
        .game_y(game_y), .game_colour(game_colour), .fill_x(fill_x),
        .fill_y(fill_y), .fill_colour(fill_colour), .fill_rst(fill_rst),
        .show_title(show_title), .show_black(show_black),
        .show_gameover(show_gameover), .flash(flash), .game_grant(game_grant),
        .busy(busy), .plot(plot), .x(x), .y(y), .colour(colour)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: named screen phase plus elapsed cycles within a fill.
    bit    m_held    = 1'b1;
    string m_phase   = "title_fill";
    int    m_elapsed = 0;
    int    m_ticks   = 0;
    int    m_flashes = 0;

    int plots_seen = 0, rst_seen = 0, title_seen = 0, black_seen = 0;

    typedef struct {
        logic       req;
        logic [7:0] gx;
        logic [6:0] gy;
        logic [2:0] gc;
        logic       e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
    } play_vec_t;

    play_vec_t vecs[5];

    function automatic bit is_fill_phase(input string p);
        return (p == "title_fill") || (p == "clear_fill") ||
               (p == "over_fill")  || (p == "flash_fill");
    endfunction

    function automatic logic [25:0] dutVec();
        return {fill_rst, show_title, show_black, show_gameover, flash,
                game_grant, busy, plot, x, y, colour};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelCheck();
        logic       fr, st, sb, sg, fl, gg, bz, pl;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        {fr, st, sb, sg, fl, gg, bz, pl} = '0;
        ex = '0; ey = '0; ec = '0;
        if (!m_held) begin
            if (is_fill_phase(m_phase)) begin
                bz = 1'b1;
                fr = (m_elapsed == 0);
                pl = (m_elapsed != 0);
                ex = fill_x; ey = fill_y; ec = fill_colour;
                if (m_phase == "title_fill") st = 1'b1;
                if (m_phase == "clear_fill") sb = 1'b1;
                if (m_phase == "over_fill")  sg = 1'b1;
                if (m_phase == "flash_fill") begin
                    if (m_flashes % 2 == 0) fl = 1'b1;
                    else st = 1'b1;
                end
            end else if (m_phase == "play") begin
                gg = 1'b1;
                pl = game_req && !game_over;
                ex = game_x; ey = game_y; ec = game_colour;
            end
        end
        checkOutput("model", 32'(dutVec()), 32'({fr, st, sb, sg, fl, gg, bz, pl, ex, ey, ec}));
        if (plot === 1'b1)       plots_seen++;
        if (fill_rst === 1'b1)   rst_seen++;
        if (show_title === 1'b1) title_seen++;
        if (show_black === 1'b1) black_seen++;
    endtask

    task automatic modelStep();
        if (rst) begin
            m_held = 1'b1; m_phase = "title_fill";
            m_elapsed = 0; m_ticks = 0; m_flashes = 0;
        end else if (m_held) begin
            m_held = 1'b0;
        end else if (is_fill_phase(m_phase)) begin
            if (m_elapsed == PIX) begin
                m_elapsed = 0;
                if (m_phase == "title_fill") m_phase = "title_wait";
                else if (m_phase == "clear_fill") m_phase = "play";
                else if (m_phase == "over_fill") begin
                    m_phase = "flash_wait"; m_ticks = 0; m_flashes = 0;
                end else begin
                    m_flashes++;
                    m_phase = (m_flashes == FC) ? "title_wait" : "flash_wait";
                end
            end else begin
                m_elapsed++;
            end
        end else if (m_phase == "title_wait") begin
            if (start_key) m_phase = "clear_fill";
        end else if (m_phase == "play") begin
            if (game_over) m_phase = "over_fill";
        end else if (m_phase == "flash_wait") begin
            if (frame_tick) begin
                m_ticks++;
                if (m_ticks == FF) begin
                    m_ticks = 0;
                    m_phase = "flash_fill";
                end
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        modelCheck();
        fill_x      = 8'($urandom);
        fill_y      = 7'($urandom);
        fill_colour = 3'($urandom);
    endtask

    task automatic step();
        applyStimulus();
        sampleCycle();
    endtask

    int base_plot, base_rst, base_title, base_black;

    initial begin
        vecs[0] = '{1'b1, 8'd10,  7'd20,  3'b010, 1'b1, 8'd10,  7'd20,  3'b010};
        vecs[1] = '{1'b0, 8'd10,  7'd20,  3'b010, 1'b0, 8'd10,  7'd20,  3'b010};
        vecs[2] = '{1'b1, 8'd0,   7'd0,   BLACK,  1'b1, 8'd0,   7'd0,   BLACK};
        vecs[3] = '{1'b1, 8'd159, 7'd119, RED,    1'b1, 8'd159, 7'd119, RED};
        vecs[4] = '{1'b1, 8'd255, 7'd127, 3'b111, 1'b1, 8'd255, 7'd127, 3'b111};

        rst = 1'b1; start_key = 1'b0; game_over = 1'b0; frame_tick = 1'b0;
        game_req = 1'b0; game_x = '0; game_y = '0; game_colour = '0;
        fill_x = '0; fill_y = '0; fill_colour = '0;

        repeat (3) step();
        checkOutput("reset_outputs", 32'(dutVec()), 32'd0);

        // Title fill after reset release
        base_plot = plots_seen; base_rst = rst_seen; base_title = title_seen;
        rst = 1'b0;
        step();
        checkOutput("title_entry_fill_rst", 32'(fill_rst), 32'd1);
        checkOutput("title_entry_show", 32'(show_title), 32'd1);
        checkOutput("title_entry_plot", 32'(plot), 32'd0);
        repeat (PIX + 2) step();
        checkOutput("title_plots", 32'(plots_seen - base_plot), 32'(PIX));
        checkOutput("title_fill_rsts", 32'(rst_seen - base_rst), 32'd1);
        checkOutput("title_cycles", 32'(title_seen - base_title), 32'(PIX + 1));
        checkOutput("title_wait_busy", 32'(busy), 32'd0);

        // Clear fill on start_key
        base_plot = plots_seen; base_black = black_seen;
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        checkOutput("clear_entry_show", 32'(show_black), 32'd1);
        checkOutput("clear_entry_fill_rst", 32'(fill_rst), 32'd1);
        repeat (PIX + 2) step();
        checkOutput("clear_plots", 32'(plots_seen - base_plot), 32'(PIX));
        checkOutput("clear_cycles", 32'(black_seen - base_black), 32'(PIX + 1));
        checkOutput("play_grant", 32'(game_grant), 32'd1);
        checkOutput("play_busy", 32'(busy), 32'd0);

        // PLAY plot-port mux table
        for (int i = 0; i < 5; i++) begin
            game_req = vecs[i].req; game_x = vecs[i].gx;
            game_y = vecs[i].gy; game_colour = vecs[i].gc;
            step();
            checkOutput($sformatf("play_vec%0d_plot", i), 32'(plot), 32'(vecs[i].e_plot));
            checkOutput($sformatf("play_vec%0d_x", i), 32'(x), 32'(vecs[i].e_x));
            checkOutput($sformatf("play_vec%0d_y", i), 32'(y), 32'(vecs[i].e_y));
            checkOutput($sformatf("play_vec%0d_colour", i), 32'(colour), 32'(vecs[i].e_c));
        end

        // game_over beats a same-cycle game_req
        game_over = 1'b1; game_req = 1'b1; game_x = 8'd33;
        #2;
        checkOutput("over_no_plot", 32'(plot), 32'd0);
        checkOutput("over_still_grant", 32'(game_grant), 32'd1);
        step();
        game_over = 1'b0; game_req = 1'b0;
        checkOutput("gameover_entry_show", 32'(show_gameover), 32'd1);
        checkOutput("gameover_entry_fill_rst", 32'(fill_rst), 32'd1);
        checkOutput("gameover_entry_grant", 32'(game_grant), 32'd0);
        repeat (PIX + 2) step();

        // Flash sequence: FC fills, each after FF frame ticks
        for (int f = 0; f < FC; f++) begin
            for (int t = 0; t < FF - 1; t++) begin
                frame_tick = 1'b1; start_key = 1'b1;
                step();
                frame_tick = 1'b0; start_key = 1'b0;
                step();
                step();
            end
            checkOutput($sformatf("flash%0d_wait_busy", f), 32'(busy), 32'd0);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            checkOutput($sformatf("flash%0d_fill_rst", f), 32'(fill_rst), 32'd1);
            checkOutput($sformatf("flash%0d_flash", f), 32'(flash), 32'((f % 2) == 0));
            checkOutput($sformatf("flash%0d_title", f), 32'(show_title), 32'((f % 2) == 1));
            repeat (PIX + 2) step();
        end
        checkOutput("after_flash_busy", 32'(busy), 32'd0);
        checkOutput("after_flash_title", 32'(show_title), 32'd0);

        // Back in title wait: start_key begins a clear fill, then reset mid-fill
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        checkOutput("restart_clear_show", 32'(show_black), 32'd1);
        checkOutput("restart_clear_fill_rst", 32'(fill_rst), 32'd1);
        repeat (500) step();
        checkOutput("mid_fill_plot", 32'(plot), 32'd1);
        rst = 1'b1;
        step();
        checkOutput("mid_fill_reset", 32'(dutVec()), 32'd0);
        rst = 1'b0;
        step();
        checkOutput("post_reset_fill_rst", 32'(fill_rst), 32'd1);
        checkOutput("post_reset_title", 32'(show_title), 32'd1);

        // Randomized run against the reference model
        for (int i = 0; i < 25000; i++) begin
            rst         = ($urandom % 4000) == 0;
            start_key   = ($urandom % 40) == 0;
            game_over   = ($urandom % 300) == 0;
            frame_tick  = ($urandom % 3) == 0;
            game_req    = 1'($urandom);
            game_x      = 8'($urandom);
            game_y      = 7'($urandom);
            game_colour = 3'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
